fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction prefetch buffer between the ROM port and the IF/ID register.
- Replaces the direct pc_reg-to-ROM-to-if_id path. Keeps up to DEPTH fetched instructions, each tagged with its address.
- Adds a valid/ready handshake toward decode, so a decode stall no longer stalls the ROM.
- Supports redirect (jump or interrupt flush) and tags misaligned fetch addresses.

Parameters:
- ADDR_WIDTH, 32: instruction address width.
- DATA_WIDTH, 32: instruction word width.
- DEPTH, 4: number of FIFO entries. Must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- CNT_W, $clog2(DEPTH+1): occupancy counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- rom_ce_o  out  1  ROM read request for this cycle.
- rom_addr_o  out  ADDR_WIDTH  ROM read address; equals fetch_pc.
- rom_data_i  in  DATA_WIDTH  ROM read data; valid in the cycle after the request.
- flush_i  in  1  redirect (jump flush OR interrupt flush).
- new_pc_i  in  ADDR_WIDTH  redirect target; sampled when flush_i=1.
- valid_o  out  1  head entry is valid.
- inst_o  out  DATA_WIDTH  head instruction.
- inst_addr_o  out  ADDR_WIDTH  head instruction address.
- misalign_o  out  1  head entry's address has [1:0] != 0.
- ready_i  in  1  decode accepts the head this cycle.
- count_o  out  CNT_W  current number of valid entries.

Behaviour:
- Reset (rst_i=1 at an edge):
  - fetch_pc = RESET_PC; FIFO pointers and count = 0; inflight = 0; halt = 0.
  - Outputs while in reset: valid_o=0, count_o=0, inst_o=0, inst_addr_o=0, misalign_o=0, rom_ce_o=0.
  - Reset asserted mid-operation discards all entries and any in-flight response.
- Pop: occurs when valid_o & ready_i. The read pointer advances modulo DEPTH.
- Issue condition (combinational):
  - rom_ce_o = !rst_i & !flush_i & !halt & ((count + inflight - pop) < DEPTH).
  - The FIFO can therefore never overflow, including push and pop in the same cycle when full.
- On issue:
  - inflight<=1; tag_addr<=fetch_pc; tag_mis<=(fetch_pc[1:0]!=0).
  - fetch_pc<=fetch_pc+4.
  - If fetch_pc is misaligned, set halt<=1. No further issue until flush or reset.
- Response:
  - In the cycle where inflight=1 and no flush, write {rom_data_i, tag_addr, tag_mis} at the write pointer.
  - inflight clears unless a new issue occurs in the same cycle.
  - Throughput is one instruction per cycle in steady state for any DEPTH>=2.
- Count update: count changes by +push-pop. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Latency: the head is visible (valid_o=1) one cycle after its response is written. There is no bypass: request in cycle N, data in N+1, valid_o in N+2.
- Flush (highest priority after reset):
  - Clears all entries (count<=0, pointers<=0).
  - Kills any in-flight response: the rom_data_i of the next cycle is ignored.
  - fetch_pc<=new_pc_i; halt<=0; no issue in the flush cycle.
  - valid_o=0 in the cycle after flush. The first new request is issued in the cycle after flush, and its entry is valid 3 cycles after the flush cycle.
- Flush during a pop: the pop is still counted as taken by decode, and the FIFO is cleared anyway.
- ready_i while valid_o=0 has no effect.
- The head outputs (inst_o, inst_addr_o, misalign_o) hold stable while valid_o=1 & ready_i=0.
- Misaligned entries are delivered in order. Only the address is flagged; the data content is don't-care.
- Outputs are 0 whenever valid_o=0.

Test Plan:
- Reset release, ready_i=1, ROM returns addr^32'hA5A5_0000:
  - Requests go to 0x0, 0x4, 0x8 on consecutive cycles.
  - valid_o first rises 2 cycles after the first request.
  - Heads are 0x0, 0x4, 0x8 with matching data, one per cycle.
- ready_i=0 from reset, DEPTH=4:
  - Exactly 4 requests are issued; count_o saturates at 4; rom_ce_o stays 0.
  - Raising ready_i pops 0x0 and re-enables issue in the same cycle; no entry is lost or duplicated.
- Steady state, full, ready_i=1: push and pop in every cycle; count_o stays constant; the address sequence is contiguous across pointer wrap (≥12 entries).
- flush_i with new_pc_i=0x100 while count=3 and inflight=1:
  - Next cycle: valid_o=0, count_o=0, and the stale ROM response is dropped.
  - First head after the flush is 0x100, 3 cycles after the flush.
- flush_i with new_pc_i=0x102:
  - One entry with inst_addr_o=0x102 and misalign_o=1, then no further rom_ce_o.
  - A subsequent flush to 0x200 resumes normal fetch.
- rst_i asserted with count=2: next cycle all outputs are 0; after release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between the ROM port and IF/ID.
//
// Keeps up to DEPTH fetched instructions, each tagged with its address and
// a misalignment flag, and presents them to decode through a valid/ready
// handshake so that a decode stall does not stall the ROM.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   rom_ce_o     ROM read request this cycle
//   rom_addr_o   ROM read address (the current fetch pc)
//   rom_data_i   ROM read data, valid the cycle after the request
//   flush_i      redirect (jump or interrupt flush)
//   new_pc_i     redirect target, sampled while flush_i=1
//   valid_o      head entry valid
//   inst_o       head instruction
//   inst_addr_o  head instruction address
//   misalign_o   head address has [1:0] != 0
//   ready_i      decode accepts the head this cycle
//   count_o      number of valid entries
//
// Handshake: the head transfers to decode in every cycle where
// valid_o & ready_i are both 1. While valid_o=1 and ready_i=0 the head
// outputs hold stable. ready_i has no effect while valid_o=0. All head
// outputs read 0 whenever valid_o=0.
module fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  rom_ce_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] new_pc_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  output logic                  misalign_o,
  input  logic                  ready_i,
  output logic [CNT_W-1:0]      count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = CNT_W + 1;

  // Entry storage (no reset needed: reads are gated by valid_o)
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
  logic                  mem_mis_q  [DEPTH];

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] tag_addr_q, tag_addr_d;
  logic                  tag_mis_q, tag_mis_d;
  logic                  halt_q, halt_d;
  logic                  inflight_q, inflight_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [OCC_W-1:0]      occ_after;

  assign valid_o = !rst_i && (count_q != '0);
  assign pop     = valid_o && ready_i;
  // A response is written only if no redirect or reset kills it this cycle.
  assign push    = !rst_i && !flush_i && inflight_q;

  // Projected occupancy counting the outstanding response: issuing only
  // when it stays below DEPTH guarantees the FIFO can never overflow,
  // even with push and pop together on a full queue.
  assign occ_after = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issue     = !rst_i && !flush_i && !halt_q && (occ_after < OCC_W'(DEPTH));

  assign rom_ce_o    = issue;
  assign rom_addr_o  = fetch_pc_q;
  assign count_o     = rst_i ? '0 : count_q;
  assign inst_o      = valid_o ? mem_data_q[rd_ptr_q] : '0;
  assign inst_addr_o = valid_o ? mem_addr_q[rd_ptr_q] : '0;
  assign misalign_o  = valid_o ? mem_mis_q[rd_ptr_q]  : 1'b0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_addr_d = tag_addr_q;
    tag_mis_d  = tag_mis_q;
    halt_d     = halt_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (flush_i) begin
      // Redirect drops every entry and the pending response; fetching
      // resumes at the target in the next cycle.
      fetch_pc_d = new_pc_i;
      halt_d     = 1'b0;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      inflight_d = issue;
      if (issue) begin
        tag_addr_d = fetch_pc_q;
        tag_mis_d  = (fetch_pc_q[1:0] != 2'b00);
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
        // A misaligned fetch is the last one until the next redirect.
        if (fetch_pc_q[1:0] != 2'b00) halt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      tag_addr_q <= '0;
      tag_mis_q  <= 1'b0;
      halt_q     <= 1'b0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_addr_q <= tag_addr_d;
      tag_mis_q  <= tag_mis_d;
      halt_q     <= halt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= rom_data_i;
      mem_addr_q[wr_ptr_q] <= tag_addr_q;
      mem_mis_q[wr_ptr_q]  <= tag_mis_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a queue-based
// reference model compared every cycle plus hand-computed checkpoints.
module tb_fetch_queue;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;
  localparam int          EW    = DW + AW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i      = 1'b1;
  logic          flush_i    = 1'b0;
  logic [AW-1:0] new_pc_i   = '0;
  logic          ready_i    = 1'b1;
  logic [DW-1:0] rom_data_i = '0;

  logic          rom_ce_o;
  logic [AW-1:0] rom_addr_o;
  logic          valid_o;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_addr_o;
  logic          misalign_o;
  logic [CW-1:0] count_o;

  fetch_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .flush_i(flush_i), .new_pc_i(new_pc_i),
    .valid_o(valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .misalign_o(misalign_o), .ready_i(ready_i), .count_o(count_o)
  );

  // ROM: answers the previous cycle's request with addr ^ MAGIC.
  always @(posedge clk)
    rom_data_i <= rom_ce_o ? (rom_addr_o ^ MAGIC) : 32'hDEAD_BEEF;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: list of delivered-to-be entries {data, addr, mis}.
  logic [EW-1:0] exp_q[$];
  int            m_inflight = 0;
  logic [AW-1:0] m_tag      = '0;
  logic [AW-1:0] m_pc       = '0;
  bit            m_halt     = 0;

  function automatic bit m_pop();
    return !rst_i && (exp_q.size() != 0) && ready_i;
  endfunction

  function automatic bit m_issue();
    int occ;
    occ = exp_q.size() + m_inflight - (m_pop() ? 1 : 0);
    return !rst_i && !flush_i && !m_halt && (occ < DEPTH);
  endfunction

  always @(posedge clk) begin : model
    bit p, iss;
    p   = m_pop();
    iss = m_issue();
    if (rst_i) begin
      exp_q.delete(); m_inflight = 0; m_halt = 0; m_pc = 32'h0;
    end else if (flush_i) begin
      exp_q.delete(); m_inflight = 0; m_halt = 0; m_pc = new_pc_i;
    end else begin
      if (p) void'(exp_q.pop_front());
      if (m_inflight != 0) exp_q.push_back({m_tag ^ MAGIC, m_tag, m_tag[1:0] != 2'b00});
      if (iss) begin
        m_inflight = 1;
        m_tag      = m_pc;
        if (m_pc[1:0] != 2'b00) m_halt = 1;
        m_pc = m_pc + 32'd4;
      end else begin
        m_inflight = 0;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin : compare
    logic [EW-1:0] head;
    bit            e_valid, e_ce;
    e_valid = !rst_i && exp_q.size() != 0;
    head    = e_valid ? exp_q[0] : '0;
    e_ce    = m_issue();
    chk("m_valid", EW'(valid_o), EW'(e_valid));
    chk("m_count", EW'(count_o), rst_i ? '0 : EW'(exp_q.size()));
    chk("m_addr",  EW'(inst_addr_o), EW'(head[AW:1]));
    chk("m_mis",   EW'(misalign_o), EW'(head[0]));
    if (!head[0]) chk("m_inst", EW'(inst_o), EW'(head[EW-1:AW+1]));
    chk("m_ce",    EW'(rom_ce_o), EW'(e_ce));
    if (e_ce) chk("m_romaddr", EW'(rom_addr_o), EW'(m_pc));
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset and first fetches with decode always ready
    repeat (3) next_cycle();
    settle();
    chk("rst_valid", EW'(valid_o), '0);
    chk("rst_count", EW'(count_o), '0);
    chk("rst_ce",    EW'(rom_ce_o), '0);
    chk("rst_inst",  EW'(inst_o), '0);
    next_cycle(); rst_i = 1'b0; settle();
    chk("c0_ce", EW'(rom_ce_o), 1); chk("c0_addr", EW'(rom_addr_o), 32'h0);
    next_cycle(); settle();
    chk("c1_addr", EW'(rom_addr_o), 32'h4); chk("c1_valid", EW'(valid_o), 0);
    next_cycle(); settle();
    chk("c2_addr", EW'(rom_addr_o), 32'h8); chk("c2_valid", EW'(valid_o), 1);
    chk("c2_head", EW'(inst_addr_o), 32'h0); chk("c2_inst", EW'(inst_o), 32'hA5A5_0000);
    next_cycle(); settle();
    chk("c3_head", EW'(inst_addr_o), 32'h4); chk("c3_inst", EW'(inst_o), 32'hA5A5_0004);
    next_cycle(); settle();
    chk("c4_head", EW'(inst_addr_o), 32'h8);

    // Fill with decode stalled
    next_cycle(); rst_i = 1'b1; ready_i = 1'b0;
    next_cycle(); rst_i = 1'b0; settle();
    chk("r0_addr", EW'(rom_addr_o), 32'h0);
    repeat (5) next_cycle();
    settle();
    chk("r5_count", EW'(count_o), 4); chk("r5_ce", EW'(rom_ce_o), 0);
    chk("r5_head", EW'(inst_addr_o), 32'h0);
    repeat (2) next_cycle();
    settle();
    chk("r7_count", EW'(count_o), 4); chk("r7_ce", EW'(rom_ce_o), 0);

    // Release decode: pop and issue in the same cycle, then steady state
    next_cycle(); ready_i = 1'b1; settle();
    chk("r8_ce", EW'(rom_ce_o), 1); chk("r8_romaddr", EW'(rom_addr_o), 32'h10);
    for (int k = 0; k < 16; k++) begin
      chk("ss_valid", EW'(valid_o), 1);
      chk("ss_head",  EW'(inst_addr_o), EW'(32'(4 * k)));
      chk("ss_count", EW'(count_o), (k == 0) ? EW'(4) : EW'(3));
      next_cycle();
    end

    // Flush to 0x100 with count=3 and a response in flight
    flush_i = 1'b1; new_pc_i = 32'h100; settle();
    chk("f0_ce", EW'(rom_ce_o), 0); chk("f0_count", EW'(count_o), 3);
    next_cycle(); flush_i = 1'b0; settle();
    chk("f1_valid", EW'(valid_o), 0); chk("f1_count", EW'(count_o), 0);
    chk("f1_romaddr", EW'(rom_addr_o), 32'h100);
    next_cycle(); settle();
    chk("f2_valid", EW'(valid_o), 0); chk("f2_count", EW'(count_o), 0);
    next_cycle(); settle();
    chk("f3_valid", EW'(valid_o), 1); chk("f3_head", EW'(inst_addr_o), 32'h100);
    chk("f3_inst", EW'(inst_o), 32'hA5A5_0100);

    // Misaligned redirect
    next_cycle(); flush_i = 1'b1; new_pc_i = 32'h102;
    next_cycle(); flush_i = 1'b0; settle();
    chk("g1_ce", EW'(rom_ce_o), 1); chk("g1_romaddr", EW'(rom_addr_o), 32'h102);
    next_cycle(); settle();
    chk("g2_ce", EW'(rom_ce_o), 0);
    next_cycle(); settle();
    chk("g3_head", EW'(inst_addr_o), 32'h102); chk("g3_mis", EW'(misalign_o), 1);
    next_cycle(); settle();
    chk("g4_valid", EW'(valid_o), 0); chk("g4_ce", EW'(rom_ce_o), 0);
    repeat (3) next_cycle();
    settle();
    chk("g7_ce", EW'(rom_ce_o), 0); chk("g7_count", EW'(count_o), 0);

    // Redirect to 0x200 resumes fetch
    next_cycle(); flush_i = 1'b1; new_pc_i = 32'h200;
    next_cycle(); flush_i = 1'b0; settle();
    chk("h1_romaddr", EW'(rom_addr_o), 32'h200); chk("h1_ce", EW'(rom_ce_o), 1);
    next_cycle();
    next_cycle(); ready_i = 1'b0; settle();
    chk("h3_head", EW'(inst_addr_o), 32'h200); chk("h3_mis", EW'(misalign_o), 0);

    // Reset with two entries held
    next_cycle(); settle();
    chk("h4_count", EW'(count_o), 2);
    rst_i = 1'b1; settle();
    chk("h4_rstcount", EW'(count_o), 0); chk("h4_rstvalid", EW'(valid_o), 0);
    next_cycle(); settle();
    chk("h5_valid", EW'(valid_o), 0); chk("h5_count", EW'(count_o), 0);
    chk("h5_ce", EW'(rom_ce_o), 0); chk("h5_addr", EW'(inst_addr_o), 0);
    next_cycle(); rst_i = 1'b0; ready_i = 1'b1; settle();
    chk("h6_count", EW'(count_o), 0); chk("h6_romaddr", EW'(rom_addr_o), 32'h0);
    next_cycle(); settle();
    chk("h7_valid", EW'(valid_o), 0);
    next_cycle(); settle();
    chk("h8_head", EW'(inst_addr_o), 32'h0); chk("h8_valid", EW'(valid_o), 1);
    repeat (4) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
